// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the staged reset sequencer.
package reset_seq_pkg;

    localparam int CNT_W = 8;
    localparam int STG_W = 3;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

endpackage

// File: rtl/reset_sequencer_timer.sv
// Saturating stage timer with compare flags for the hold and timeout limits.
module seq_timer
    import reset_seq_pkg::*;
#(
    parameter int HOLD    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iCLR,
    input  logic iEN,
    output logic oHOLD_HIT,
    output logic oHOLD_DONE,
    output logic oTIMEOUT_HIT
);

    logic [CNT_W-1:0] cnt;

    // Saturates at all-ones so a long wait can never wrap back into a compare.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt <= '0;
        end else if (iCLR) begin
            cnt <= '0;
        end else if (iEN && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign oHOLD_HIT    = (cnt == CNT_W'(HOLD - 1));
    assign oHOLD_DONE   = (cnt >= CNT_W'(HOLD - 1));
    assign oTIMEOUT_HIT = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/reset_sequencer.sv
// Closed-loop staged reset release with ready handshake and ordered shutdown.
// iREADY[k] is sampled every cycle; a stage counts as up once its ready is high after the hold time.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int HOLD       = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSHUTDOWN,
    input  logic [NUM_STAGES-1:0] iREADY,
    output logic [NUM_STAGES-1:0] oRST,
    output logic                  oALL_UP,
    output logic                  oDOWN,
    output logic                  oFAULT,
    output logic [2:0]            oFAULT_STAGE,
    output state_t                oSTATE
);

    localparam logic [STG_W-1:0] LAST_K = STG_W'(NUM_STAGES - 1);

    state_t                  state, stateNext;
    logic [STG_W-1:0]        k, kNext, faultIdx, lowZero;
    logic                    readyK, cntClr;
    logic                    holdHit, holdDone, timeoutHit;
    logic [NUM_STAGES-1:0]   rstNext;
    logic                    allUpNext, downNext, faultNext;
    logic [2:0]              stageNext;

    seq_timer #(.HOLD(HOLD), .TIMEOUT(TIMEOUT)) u_timer (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iCLR         (cntClr),
        .iEN          (state != ST_FAULT),
        .oHOLD_HIT    (holdHit),
        .oHOLD_DONE   (holdDone),
        .oTIMEOUT_HIT (timeoutHit)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state        <= ST_OFF;
            k            <= '0;
            oRST         <= '0;
            oALL_UP      <= 1'b0;
            oDOWN        <= 1'b1;
            oFAULT       <= 1'b0;
            oFAULT_STAGE <= '0;
        end else begin
            state        <= stateNext;
            k            <= kNext;
            oRST         <= rstNext;
            oALL_UP      <= allUpNext;
            oDOWN        <= downNext;
            oFAULT       <= faultNext;
            oFAULT_STAGE <= stageNext;
        end
    end

    always_comb begin
        readyK  = 1'b0;
        lowZero = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (k == STG_W'(i)) readyK = iREADY[i];
            if (!iREADY[i]) lowZero = STG_W'(i);
        end
        stateNext = state;
        kNext     = k;
        faultIdx  = '0;
        case (state)
            ST_OFF: begin
                if (!iSHUTDOWN && holdHit) begin
                    stateNext = ST_RELEASE;
                    kNext     = '0;
                end
            end
            ST_RELEASE: begin
                if (iSHUTDOWN) begin
                    stateNext = ST_DRAIN;
                end else if (holdDone && readyK) begin
                    if (k == LAST_K) stateNext = ST_RUN;
                    else kNext = k + 1'b1;
                end else if (timeoutHit && !readyK) begin
                    stateNext = ST_FAULT;
                    faultIdx  = k;
                end
            end
            ST_RUN: begin
                // A lost domain outranks an orderly shutdown request.
                if (!(&iREADY)) begin
                    stateNext = ST_FAULT;
                    faultIdx  = lowZero;
                end else if (iSHUTDOWN) begin
                    stateNext = ST_DRAIN;
                    kNext     = LAST_K;
                end
            end
            ST_DRAIN: begin
                if (holdHit) begin
                    if (k != '0) kNext = k - 1'b1;
                    else stateNext = ST_OFF;
                end
            end
            default: ;
        endcase
        cntClr = (stateNext != state) || (kNext != k) || ((state == ST_OFF) && iSHUTDOWN);
    end

    always_comb begin
        rstNext   = oRST;
        allUpNext = oALL_UP;
        downNext  = oDOWN;
        faultNext = oFAULT;
        stageNext = oFAULT_STAGE;
        case (stateNext)
            ST_OFF: begin
                rstNext   = '0;
                allUpNext = 1'b0;
                downNext  = 1'b1;
            end
            ST_RELEASE: begin
                for (int i = 0; i < NUM_STAGES; i++) rstNext[i] = (STG_W'(i) <= kNext);
                allUpNext = 1'b0;
                downNext  = 1'b0;
            end
            ST_RUN: begin
                rstNext   = '1;
                allUpNext = 1'b1;
                downNext  = 1'b0;
            end
            ST_DRAIN: begin
                // Stages at or above k are held in reset; lower ones stay as they were.
                for (int i = 0; i < NUM_STAGES; i++) rstNext[i] = oRST[i] && (STG_W'(i) < kNext);
                allUpNext = 1'b0;
                downNext  = 1'b0;
            end
            ST_FAULT: begin
                rstNext   = '0;
                allUpNext = 1'b0;
                downNext  = 1'b0;
                faultNext = 1'b1;
                if (state != ST_FAULT) stageNext = faultIdx;
            end
            default: ;
        endcase
    end

    assign oSTATE = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: stimulus pushes expected output changes with their cycle, a monitor pops and compares.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int W = 25;
    localparam logic [8:0] RST_VAL = 9'b000_0_1_0_000;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iSHUTDOWN = 1'b0;
    logic [2:0] readyMask = 3'b111;
    logic [2:0] iREADY, oRST;
    logic       oALL_UP, oDOWN, oFAULT;
    logic [2:0] oFAULT_STAGE;
    state_t     oSTATE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    logic [W-1:0] exp_q[$];

    reset_sequencer #(.NUM_STAGES(3), .HOLD(16), .TIMEOUT(64)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iSHUTDOWN    (iSHUTDOWN),
        .iREADY       (iREADY),
        .oRST         (oRST),
        .oALL_UP      (oALL_UP),
        .oDOWN        (oDOWN),
        .oFAULT       (oFAULT),
        .oFAULT_STAGE (oFAULT_STAGE),
        .oSTATE       (oSTATE)
    );

    // Domains acknowledge as soon as they are released unless masked off.
    assign iREADY = oRST & readyMask;

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc++;

    function automatic logic [8:0] pk(input logic [2:0] r, input logic a, input logic d,
                                      input logic f, input logic [2:0] s);
        return {r, a, d, f, s};
    endfunction

    task automatic push(input int rel, input logic [8:0] v);
        int t;
        t = base + rel;
        exp_q.push_back({t[15:0], v});
    endtask

    task automatic push_startup(input int off);
        push(off + 16, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        push(off + 32, pk(3'b011, 1'b0, 1'b0, 1'b0, 3'd0));
        push(off + 48, pk(3'b111, 1'b0, 1'b0, 1'b0, 3'd0));
        push(off + 64, pk(3'b111, 1'b1, 1'b0, 1'b0, 3'd0));
    endtask

    // Monitor: every change of the output vector is one scoreboard event.
    logic [8:0]   mon_prev = RST_VAL;
    logic [8:0]   mon_cur;
    logic [W-1:0] mon_exp;
    int           mon_t;
    always @(negedge iCLK) begin
        mon_cur = {oRST, oALL_UP, oDOWN, oFAULT, oFAULT_STAGE};
        if (!iRST) begin
            mon_prev = RST_VAL;
        end else if (mon_cur !== mon_prev) begin
            checks++;
            mon_t = cyc;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d out=%b expected no change", cyc, mon_cur);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mon_t[15:0], mon_cur} !== mon_exp) begin
                    errors++;
                    $display("FAIL event got cyc=%0d out=%b, expected cyc=%0d out=%b",
                             cyc, mon_cur, mon_exp[W-1:9], mon_exp[8:0]);
                end
            end
            mon_prev = mon_cur;
        end
    end

    task automatic check_out(input string name, input logic [8:0] expv);
        logic [8:0] got;
        got = {oRST, oALL_UP, oDOWN, oFAULT, oFAULT_STAGE};
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, expv);
        end
    endtask

    task automatic do_reset();
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);
        check_out("reset_state", RST_VAL);
        iRST = 1'b1;
        base = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events remaining=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // Power-up with ready following release.
        do_reset();
        push_startup(0);
        wait_drain(200);
        quiet(20);

        // One-cycle shutdown pulse from RUN, full drain, then automatic restart.
        base = cyc;
        iSHUTDOWN = 1'b1;
        push(1,  pk(3'b011, 1'b0, 1'b0, 1'b0, 3'd0));
        push(17, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        push(33, pk(3'b000, 1'b0, 1'b0, 1'b0, 3'd0));
        push(49, pk(3'b000, 1'b0, 1'b1, 1'b0, 3'd0));
        push_startup(49);
        @(negedge iCLK);
        iSHUTDOWN = 1'b0;
        wait_drain(300);
        quiet(10);

        // Asynchronous reset in the middle of a drain at k=1.
        base = cyc;
        iSHUTDOWN = 1'b1;
        push(1,  pk(3'b011, 1'b0, 1'b0, 1'b0, 3'd0));
        push(17, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        @(negedge iCLK);
        iSHUTDOWN = 1'b0;
        wait_drain(40);
        @(posedge iCLK);
        #2;
        iRST = 1'b0;
        #1;
        check_out("async_reset", RST_VAL);

        // Stage 1 acknowledges 40 cycles after its release.
        readyMask = 3'b101;
        do_reset();
        push(16, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        push(32, pk(3'b011, 1'b0, 1'b0, 1'b0, 3'd0));
        push(73, pk(3'b111, 1'b0, 1'b0, 1'b0, 3'd0));
        push(89, pk(3'b111, 1'b1, 1'b0, 1'b0, 3'd0));
        quiet(72);
        readyMask = 3'b111;
        wait_drain(60);
        quiet(10);

        // Stage 1 never acknowledges: timeout fault.
        readyMask = 3'b101;
        do_reset();
        push(16, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        push(32, pk(3'b011, 1'b0, 1'b0, 1'b0, 3'd0));
        push(96, pk(3'b000, 1'b0, 1'b0, 1'b1, 3'd1));
        wait_drain(150);
        quiet(30);

        // Ready loss in RUN together with shutdown: fault wins, lowest stage reported.
        readyMask = 3'b111;
        do_reset();
        push_startup(0);
        wait_drain(200);
        quiet(5);
        base = cyc;
        iSHUTDOWN = 1'b1;
        readyMask = 3'b010;
        push(1, pk(3'b000, 1'b0, 1'b0, 1'b1, 3'd0));
        quiet(3);
        iSHUTDOWN = 1'b0;
        readyMask = 3'b111;
        wait_drain(20);
        quiet(30);
        do_reset();
        push_startup(0);
        wait_drain(200);

        // Shutdown while releasing stage 1; stage 2 must stay in reset.
        do_reset();
        push(16, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        push(32, pk(3'b011, 1'b0, 1'b0, 1'b0, 3'd0));
        quiet(40);
        iSHUTDOWN = 1'b1;
        push(41, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        push(57, pk(3'b000, 1'b0, 1'b0, 1'b0, 3'd0));
        push(73, pk(3'b000, 1'b0, 1'b1, 1'b0, 3'd0));
        wait_drain(100);
        quiet(30);
        base = cyc;
        iSHUTDOWN = 1'b0;
        push(16, pk(3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        wait_drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
